// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA subtractor: nibble width and FSM encoding.
package cla_pkg;

    localparam int NIBBLE = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

endpackage

// File: rtl/cla_nibble_serial_subtractor_cla4_slice.sv
// 4-bit carry-lookahead adder slice with flat two-level carry generation.
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;

    assign p = x ^ y;
    assign g = x & y;

    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, computed one nibble per clock as a + ~b + ~bin
// through a single shared CLA slice, with valid/ready handshakes on both sides.
module cla_nibble_serial_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NNIB = WIDTH / NIBBLE;
    localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

    if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
        $error("cla_nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  nb_q;
    logic              a_msb;
    logic              b_msb;
    logic              carry;
    logic [IW-1:0]     idx;
    logic [NIBBLE-1:0] x;
    logic [NIBBLE-1:0] y;
    logic [NIBBLE-1:0] s;
    logic              co;
    logic              accept;

    assign accept = (state == S_IDLE) && in_valid;

    assign x = a_q[NIBBLE*idx +: NIBBLE];
    assign y = nb_q[NIBBLE*idx +: NIBBLE];

    cla4_slice u_slice (
        .x  (x),
        .y  (y),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // Operand capture: data only, qualified by accept, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= a;
            nb_q  <= ~b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end
    end

    // Control FSM, carry chain and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        carry    <= ~bin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff[NIBBLE*idx +: NIBBLE] <= s;
                    carry <= co;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        // Borrow is the inverted carry of a + ~b + ~bin
                        bout      <= ~co;
                        ovf       <= (a_msb != b_msb) && (s[NIBBLE-1] != a_msb);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_subtractor.sv
// Self-checking bench: directed cases on a 16-bit instance plus randomized back-to-back
// traffic on 8-, 16- and 32-bit instances against an arithmetic reference model.
module tb_cla_nibble_serial_subtractor;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic [31:0] acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[3];
    logic        ir[3];
    logic        ov[3];
    logic        ordy[3];
    logic        bin_s[3];
    logic        bo[3];
    logic        of[3];
    logic [31:0] a_s[3];
    logic [31:0] b_s[3];
    logic [31:0] dv[3];
    logic [15:0] d16;
    logic [7:0]  d8;
    logic [31:0] d32;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q[3][$];
    bit   seen[3];
    bit   b2b[3];
    int   last_acc[3];

    assign dv[0] = {16'h0, d16};
    assign dv[1] = {24'h0, d8};
    assign dv[2] = d32;

    always #5 clk = ~clk;

    cla_nibble_serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0][15:0]),
        .b(b_s[0][15:0]), .bin(bin_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .diff(d16), .bout(bo[0]), .ovf(of[0]));

    cla_nibble_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1][7:0]),
        .b(b_s[1][7:0]), .bin(bin_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .diff(d8), .bout(bo[1]), .ovf(of[1]));

    cla_nibble_serial_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[2]),
        .b(b_s[2]), .bin(bin_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .diff(d32), .bout(bo[2]), .ovf(of[2]));

    function automatic int wd(int k);
        return (k == 0) ? 16 : (k == 1) ? 8 : 32;
    endfunction

    // Reference: plain integer arithmetic on the operand values
    function automatic exp_t model(int w, logic [31:0] av, logic [31:0] bv, logic bi);
        longint one = 1;
        longint ua  = longint'(av);
        longint ub  = longint'(bv);
        longint c   = bi ? 1 : 0;
        longint sa;
        longint sb;
        longint r;
        exp_t   e;
        e.d  = 32'((ua - ub - c) & ((one << w) - 1));
        e.bo = (ua < ub + c);
        sa   = av[w-1] ? ua - (one << w) : ua;
        sb   = bv[w-1] ? ub - (one << w) : ub;
        r    = sa - sb - c;
        e.ov = (r > (one << (w - 1)) - 1) || (r < -(one << (w - 1)));
        e.acc = '0;
        return e;
    endfunction

    function automatic logic [31:0] pick(int w);
        logic [31:0] m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return m;
            2:       return 32'h1 << (w - 1);
            3:       return m >> 1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every instance against the model queue
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                q[k].delete();
                seen[k] = 0;
                chk($sformatf("rst_in_ready%0d", wd(k)), ir[k], 1);
                chk($sformatf("rst_out_valid%0d", wd(k)), ov[k], 0);
                chk($sformatf("rst_diff%0d", wd(k)), dv[k], 0);
                chk($sformatf("rst_bout%0d", wd(k)), bo[k], 0);
                chk($sformatf("rst_ovf%0d", wd(k)), of[k], 0);
            end else begin
                if (ov[k]) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("spurious_out_valid%0d", wd(k)), ov[k], 0);
                    end else begin
                        e = q[k][0];
                        if (!seen[k]) begin
                            chk($sformatf("latency%0d", wd(k)), cyc - int'(e.acc), wd(k) / 4 + 1);
                            seen[k] = 1;
                        end
                        chk($sformatf("diff%0d", wd(k)), dv[k], e.d);
                        chk($sformatf("bout%0d", wd(k)), bo[k], e.bo);
                        chk($sformatf("ovf%0d", wd(k)), of[k], e.ov);
                        chk($sformatf("busy_in_ready%0d", wd(k)), ir[k], 0);
                        if (ordy[k]) begin
                            void'(q[k].pop_front());
                            seen[k] = 0;
                        end
                    end
                end
                if (iv[k] && ir[k]) begin
                    if (b2b[k] && last_acc[k] >= 0)
                        chk($sformatf("period%0d", wd(k)), cyc - last_acc[k], wd(k) / 4 + 2);
                    last_acc[k] = b2b[k] ? cyc : -1;
                    e = model(wd(k), a_s[k], b_s[k], bin_s[k]);
                    e.acc = 32'(cyc);
                    q[k].push_back(e);
                end
            end
        end
    end

    task automatic wait_accept(int k);
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ir[k]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk($sformatf("accept_timeout%0d", wd(k)), 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(logic [31:0] av, logic [31:0] bv, logic bi,
                         logic [31:0] ed, logic eb, logic eo, string nm);
        int n;
        a_s[0] = av; b_s[0] = bv; bin_s[0] = bi; iv[0] = 1;
        wait_accept(0);
        iv[0] = 0;
        n = 1;
        while (!ov[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency_edges"}, n, 5);
        chk({nm, "_diff"}, d16, ed);
        chk({nm, "_bout"}, bo[0], eb);
        chk({nm, "_ovf"}, of[0], eo);
        if (ordy[0]) begin
            @(posedge clk);
            #1;
            chk({nm, "_valid_after_handshake"}, ov[0], 0);
            chk({nm, "_ready_after_handshake"}, ir[0], 1);
        end
    endtask

    task automatic run_random(int k, int n);
        b2b[k] = 1; ordy[k] = 1;
        for (int i = 0; i < n; i++) begin
            a_s[k] = pick(wd(k));
            b_s[k] = pick(wd(k));
            bin_s[k] = 1'($urandom_range(0, 1));
            iv[k] = 1;
            wait_accept(k);
        end
        iv[k] = 0;
        for (int t = 0; t < 100 && q[k].size() != 0; t++) @(posedge clk);
        chk($sformatf("drain%0d", wd(k)), q[k].size(), 0);
        b2b[k] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 0; ordy[k] = 1; a_s[k] = '0; b_s[k] = '0; bin_s[k] = 0;
            b2b[k] = 0; last_acc[k] = -1; seen[k] = 0;
        end
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        do_op(32'h1234, 32'h0234, 0, 32'h1000, 0, 0, "t1");
        do_op(32'h0000, 32'h0001, 0, 32'hFFFF, 1, 0, "t2a");
        do_op(32'h0000, 32'h0000, 1, 32'hFFFF, 1, 0, "t2b");
        do_op(32'h8000, 32'h0001, 0, 32'h7FFF, 0, 1, "t3a");
        do_op(32'h7FFF, 32'hFFFF, 0, 32'h8000, 1, 1, "t3b");

        // Result held while the consumer stalls; a second offer waits
        ordy[0] = 0;
        do_op(32'h0005, 32'h0003, 1, 32'h0001, 0, 0, "t4");
        a_s[0] = 32'hAAAA; b_s[0] = 32'h5555; bin_s[0] = 0; iv[0] = 1;
        repeat (7) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", ov[0], 1);
            chk("t4_hold_diff", d16, 16'h0001);
            chk("t4_hold_in_ready", ir[0], 0);
        end
        ordy[0] = 1;
        @(posedge clk);
        #1;
        chk("t4_release_valid", ov[0], 0);
        chk("t4_release_in_ready", ir[0], 1);
        do_op(32'hAAAA, 32'h5555, 0, 32'h5555, 0, 1, "t4b");

        // Abort in flight with reset
        a_s[0] = 32'h1111; b_s[0] = 32'h0001; bin_s[0] = 0; iv[0] = 1;
        wait_accept(0);
        iv[0] = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("t5_in_ready", ir[0], 1);
        chk("t5_out_valid", ov[0], 0);
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("t5_no_valid", ov[0], 0);
        end
        do_op(32'hFFFF, 32'hFFFF, 0, 32'h0000, 0, 0, "t5b");

        fork
            run_random(0, 1000);
            run_random(1, 1000);
            run_random(2, 1000);
        join

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
